// File: rtl/rc4_ksa_engine.sv
// RC4 key-scheduling engine. It drives an external synchronous state RAM.
// It can fill the RAM with the identity permutation, shuffle the current
// contents with the RC4 KSA, or do both in sequence. Every swap takes five
// cycles: read s[i], compute j, read s[j], write s[i], write s[j].
module rc4_ksa_engine #(
    parameter int DATA_WIDTH  = 8,
    parameter int ADDR_WIDTH  = 8,
    parameter int MAX_KEY_LEN = 16,
    localparam int KLW        = $clog2(MAX_KEY_LEN + 1)
) (
    input  logic                                  clk,
    input  logic                                  reset_n,
    input  logic                                  start,
    input  logic                                  abort,
    input  logic [1:0]                            mode,
    input  logic [KLW-1:0]                        key_len,
    input  logic [MAX_KEY_LEN-1:0][DATA_WIDTH-1:0] key,
    output logic                                  busy,
    output logic                                  done,
    output logic                                  error,
    input  logic [DATA_WIDTH-1:0]                 ram_rdata,
    output logic [ADDR_WIDTH-1:0]                 ram_addr,
    output logic [DATA_WIDTH-1:0]                 ram_wdata,
    output logic                                  ram_we,
    output logic [ADDR_WIDTH-1:0]                 i_dbg,
    output logic [ADDR_WIDTH-1:0]                 j_dbg,
    output logic [3:0]                            state_dbg
);

    // Key index width. It is kept at least one bit wide so that a
    // single-byte key still elaborates.
    localparam int KW = (MAX_KEY_LEN > 1) ? $clog2(MAX_KEY_LEN) : 1;
    localparam logic [ADDR_WIDTH-1:0] I_LAST = '1;

    // A state index wider than a RAM word cannot be stored as a word.
    if (DATA_WIDTH < ADDR_WIDTH) begin : g_width_check
        $error("rc4_ksa_engine: DATA_WIDTH must be >= ADDR_WIDTH");
    end

    // The state_dbg encoding follows the declaration order:
    // IDLE=0, FILL=1, RI=2, CJ=3, RJ=4, WI=5, WJ=6.
    typedef enum logic [2:0] {
        S_IDLE, S_FILL, S_RI, S_CJ, S_RJ, S_WI, S_WJ
    } state_t;

    state_t                                 state, state_next;
    logic [1:0]                             mode_r;
    logic [KLW-1:0]                         key_len_r;
    logic [MAX_KEY_LEN-1:0][DATA_WIDTH-1:0] key_r;
    logic [ADDR_WIDTH-1:0]                  i, j;
    logic [KW-1:0]                          k;
    logic [DATA_WIDTH-1:0]                  si;
    logic                                   start_bad;
    logic [ADDR_WIDTH-1:0]                  j_sum;
    logic                                   k_last;

    // A fill-only run ignores key_len. Any run that shuffles needs a key
    // length of at least one byte and at most MAX_KEY_LEN bytes.
    assign start_bad = (mode == 2'b00) ||
                       ((mode != 2'b01) &&
                        ((key_len == '0) || (key_len > KLW'(MAX_KEY_LEN))));

    // Only the low ADDR_WIDTH bits of each term can reach the truncated
    // result, so the addition is done at index width.
    assign j_sum  = j + ram_rdata[ADDR_WIDTH-1:0] + key_r[k][ADDR_WIDTH-1:0];
    assign k_last = (KLW'(k) == key_len_r - KLW'(1));

    assign busy      = (state != S_IDLE);
    assign i_dbg     = i;
    assign j_dbg     = j;
    assign state_dbg = {1'b0, state};

    // State register. Reset takes effect at once, so ram_we drops without
    // waiting for a clock edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= S_IDLE;
        else          state <= state_next;
    end

    // Next-state logic and RAM port decode. The RAM port depends only on
    // the registered state, except in WI, where s[j] is forwarded straight
    // from the RAM read data.
    always_comb begin
        state_next = state;
        ram_addr   = '0;
        ram_wdata  = '0;
        ram_we     = 1'b0;
        case (state)
            S_IDLE: begin
                if (start && !abort && !start_bad)
                    state_next = (mode == 2'b10) ? S_RI : S_FILL;
            end
            S_FILL: begin
                ram_we    = 1'b1;
                ram_addr  = i;
                ram_wdata = DATA_WIDTH'(i);
                if (i == I_LAST)
                    state_next = (mode_r == 2'b11) ? S_RI : S_IDLE;
            end
            S_RI: begin
                ram_addr   = i;
                state_next = S_CJ;
            end
            S_CJ: state_next = S_RJ;
            S_RJ: begin
                ram_addr   = j;
                state_next = S_WI;
            end
            S_WI: begin
                ram_we     = 1'b1;
                ram_addr   = i;
                ram_wdata  = ram_rdata;
                state_next = S_WJ;
            end
            S_WJ: begin
                // When i == j, this write stores the original s[i] again,
                // so the swap leaves the entry unchanged.
                ram_we     = 1'b1;
                ram_addr   = j;
                ram_wdata  = si;
                state_next = (i == I_LAST) ? S_IDLE : S_RI;
            end
            default: state_next = S_IDLE;
        endcase
        if (state != S_IDLE && abort) state_next = S_IDLE;
    end

    // Datapath registers and the done/error pulses. An abort freezes the
    // datapath and suppresses done.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mode_r    <= '0;
            key_len_r <= '0;
            key_r     <= '0;
            i         <= '0;
            j         <= '0;
            k         <= '0;
            si        <= '0;
            done      <= 1'b0;
            error     <= 1'b0;
        end else begin
            done  <= 1'b0;
            error <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start && !abort) begin
                        if (start_bad) begin
                            error <= 1'b1;
                        end else begin
                            mode_r    <= mode;
                            key_len_r <= key_len;
                            key_r     <= key;
                            i         <= '0;
                            j         <= '0;
                            k         <= '0;
                        end
                    end
                end
                S_FILL: begin
                    if (!abort) begin
                        // At i == N-1 the increment wraps i to 0, which is
                        // where the shuffle starts.
                        i <= i + ADDR_WIDTH'(1);
                        if (i == I_LAST && mode_r == 2'b01) done <= 1'b1;
                    end
                end
                S_CJ: begin
                    if (!abort) begin
                        si <= ram_rdata;
                        j  <= j_sum;
                        k  <= k_last ? '0 : k + KW'(1);
                    end
                end
                S_WJ: begin
                    if (!abort) begin
                        if (i == I_LAST) done <= 1'b1;
                        else             i    <= i + ADDR_WIDTH'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_rc4_ksa_engine.sv
// Self-checking bench for rc4_ksa_engine. It uses a full-size instance and a
// 4-entry instance, each connected to a synchronous RAM model. Results are
// checked against a plain RC4 KSA reference model.
module tb_rc4_ksa_engine;
    localparam int N  = 256;
    localparam int NS = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Full-size instance.
    logic             reset_n, start, abort;
    logic [1:0]       mode;
    logic [4:0]       key_len;
    logic [15:0][7:0] key;
    logic             busy, done, error, ram_we;
    logic [7:0]       ram_rdata, ram_addr, ram_wdata, i_dbg, j_dbg;
    logic [3:0]       state_dbg;

    rc4_ksa_engine dut (
        .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
        .mode(mode), .key_len(key_len), .key(key),
        .busy(busy), .done(done), .error(error),
        .ram_rdata(ram_rdata), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_we(ram_we), .i_dbg(i_dbg), .j_dbg(j_dbg), .state_dbg(state_dbg)
    );

    // 4-entry instance.
    logic             s_start, s_abort;
    logic [1:0]       s_mode;
    logic [4:0]       s_key_len;
    logic [15:0][7:0] s_key;
    logic             s_busy, s_done, s_error, s_we;
    logic [7:0]       s_rdata, s_wdata;
    logic [1:0]       s_addr, s_i_dbg, s_j_dbg;
    logic [3:0]       s_state_dbg;

    rc4_ksa_engine #(.ADDR_WIDTH(2)) dut_s (
        .clk(clk), .reset_n(reset_n), .start(s_start), .abort(s_abort),
        .mode(s_mode), .key_len(s_key_len), .key(s_key),
        .busy(s_busy), .done(s_done), .error(s_error),
        .ram_rdata(s_rdata), .ram_addr(s_addr), .ram_wdata(s_wdata),
        .ram_we(s_we), .i_dbg(s_i_dbg), .j_dbg(s_j_dbg), .state_dbg(s_state_dbg)
    );

    // Synchronous RAMs. Read data appears the cycle after the address.
    logic [7:0] mem   [N];
    logic [7:0] mem_s [NS];
    int         wr_cnt  = 0;
    bit         overlap = 1'b0;

    always @(posedge clk) begin
        if (ram_we) begin
            mem[ram_addr] <= ram_wdata;
            wr_cnt        <= wr_cnt + 1;
        end
        ram_rdata <= mem[ram_addr];
        if (busy && done) overlap <= 1'b1;
    end

    always @(posedge clk) begin
        if (s_we) mem_s[s_addr] <= s_wdata;
        s_rdata <= mem_s[s_addr];
    end

    // Scoreboard and reference model.
    int         passed = 0, total = 0;
    int         ref_mem [N];
    logic [7:0] key_arr [16];
    int         cur_kl;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic model_fill();
        for (int x = 0; x < N; x++) ref_mem[x] = x;
    endtask

    task automatic model_ksa();
        int jj = 0, t;
        for (int ii = 0; ii < N; ii++) begin
            jj = (jj + ref_mem[ii] + int'(key_arr[ii % cur_kl])) % N;
            t = ref_mem[ii]; ref_mem[ii] = ref_mem[jj]; ref_mem[jj] = t;
        end
    endtask

    task automatic mem_check(input string tag);
        int bad = 0;
        for (int x = 0; x < N; x++) if (mem[x] !== 8'(ref_mem[x])) bad++;
        check(tag, bad, 0);
    endtask

    task automatic rand_key();
        for (int b = 0; b < 16; b++) key_arr[b] = 8'($urandom);
    endtask

    // Starts a run from IDLE and returns the done cycle. Cycle 1 is the
    // cycle just after the start-accept edge. The return value is -1 if
    // done never arrives. With scramble set, the inputs change mid-run and
    // the DUT must ignore them.
    task automatic run_big(input logic [1:0] md, input int kl, input bit scramble, output int lat);
        @(negedge clk);
        mode = md; key_len = 5'(kl); start = 1'b1;
        for (int b = 0; b < 16; b++) key[b] = key_arr[b];
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        if (scramble) begin
            mode = 2'b01; key_len = 5'($urandom_range(1, 16));
            for (int b = 0; b < 16; b++) key[b] = 8'($urandom);
        end
        lat = 1;
        while (!done && lat < 3000) begin @(negedge clk); lat++; end
        if (!done) lat = -1;
    endtask

    // A start that must be rejected: error pulses for one cycle, busy
    // stays low, and no RAM write happens.
    task automatic err_try(input string tag, input logic [1:0] md, input int kl);
        int w0;
        @(negedge clk);
        w0 = wr_cnt; mode = md; key_len = 5'(kl); start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check({tag, "_pulse"}, {error, busy}, 2'b10);
        @(negedge clk);
        check({tag, "_after"}, {error, busy, 32'(wr_cnt - w0)}, 34'd0);
    endtask

    initial begin
        int         lat, w0, cyc;
        bit         seen;
        logic [1:0] md;
        int         kl;

        reset_n = 1'b0; start = 1'b0; abort = 1'b0; mode = '0; key_len = '0; key = '0;
        s_start = 1'b0; s_abort = 1'b0; s_mode = '0; s_key_len = '0; s_key = '0;
        #12;
        check("rst_busy", busy, 1'b0);
        check("rst_done_err", {done, error}, 2'b00);
        check("rst_we", ram_we, 1'b0);
        check("rst_dbg", {i_dbg, j_dbg, state_dbg}, 20'd0);
        @(negedge clk); reset_n = 1'b1;

        // 4-entry instance, fill then shuffle, key {0}: expected [0,2,3,1] in cycle 25.
        @(negedge clk);
        s_mode = 2'b11; s_key_len = 5'd1; s_start = 1'b1;
        @(posedge clk);
        @(negedge clk); s_start = 1'b0;
        lat = 1;
        while (!s_done && lat < 200) begin @(negedge clk); lat++; end
        check("small_lat", lat, 25);
        check("small_ram", {mem_s[0], mem_s[1], mem_s[2], mem_s[3]}, 32'h00020301);

        // Fill only. key_len = 0 is legal here because no key is used.
        run_big(2'b01, 0, 1'b0, lat);
        check("fill_lat", lat, N + 1);
        model_fill();
        mem_check("fill_ram");
        w0 = wr_cnt;
        repeat (20) @(negedge clk);
        check("fill_quiet", wr_cnt - w0, 0);

        // Known key 00 03 3C, with inputs scrambled while the run is busy.
        key_arr[0] = 8'h00; key_arr[1] = 8'h03; key_arr[2] = 8'h3C; cur_kl = 3;
        run_big(2'b11, 3, 1'b1, lat);
        check("known_lat", lat, 6 * N + 1);
        model_fill(); model_ksa();
        mem_check("known_ram");

        // Random runs in every legal mode. The first run uses the maximum key length.
        for (int r = 0; r < 4; r++) begin
            md = (r == 0) ? 2'b11 : 2'($urandom_range(1, 3));
            kl = (r == 0) ? 16 : int'($urandom_range(1, 16));
            rand_key(); cur_kl = kl;
            run_big(md, kl, 1'b1, lat);
            check("rand_lat", lat, (md == 2'b01) ? N + 1 : (md == 2'b10) ? 5 * N + 1 : 6 * N + 1);
            if (md[0]) model_fill();
            if (md[1]) model_ksa();
            mem_check("rand_ram");
        end

        // start held high: a new run begins straight out of the done cycle.
        @(negedge clk);
        mode = 2'b01; start = 1'b1;
        cyc = 0;
        while (!done && cyc < 3000) begin @(negedge clk); cyc++; end
        check("hold_done", {done, busy}, 2'b10);
        @(negedge clk);
        start = 1'b0;
        check("hold_restart", busy, 1'b1);
        cyc = 0;
        while (!done && cyc < 3000) begin @(negedge clk); cyc++; end
        check("hold_done2", done, 1'b1);

        // Rejected starts, then abort and start together in IDLE.
        err_try("err_len0", 2'b11, 0);
        err_try("err_mode0", 2'b00, 5);
        err_try("err_len17", 2'b10, 17);
        @(negedge clk);
        mode = 2'b11; key_len = 5'd3; start = 1'b1; abort = 1'b1;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        check("abort_start", {error, busy}, 2'b00);

        // Abort in WI of iteration 10 (state_dbg 5, i = 10).
        rand_key(); kl = int'($urandom_range(1, 16)); cur_kl = kl;
        @(negedge clk);
        mode = 2'b11; key_len = 5'(kl); start = 1'b1;
        for (int b = 0; b < 16; b++) key[b] = key_arr[b];
        @(negedge clk); start = 1'b0;
        cyc = 0;
        while (!(state_dbg == 4'd5 && i_dbg == 8'd10) && cyc < 4000) begin @(negedge clk); cyc++; end
        check("abort_reach_wi", {state_dbg, i_dbg}, {4'd5, 8'd10});
        abort = 1'b1;
        @(posedge clk); #1;
        check("abort_idle", {busy, ram_we}, 2'b00);
        @(negedge clk); abort = 1'b0;
        w0 = wr_cnt; seen = 1'b0;
        repeat (10) begin @(negedge clk); if (done) seen = 1'b1; end
        check("abort_no_done", {seen, 32'(wr_cnt - w0)}, 33'd0);
        run_big(2'b11, kl, 1'b0, lat);
        check("abort_restart_lat", lat, 6 * N + 1);
        model_fill(); model_ksa();
        mem_check("abort_restart_ram");

        // Reset pulse during FILL clears the outputs without a clock edge.
        @(negedge clk);
        mode = 2'b01; start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (50) @(negedge clk);
        check("rstfill_busy_pre", busy, 1'b1);
        @(posedge clk); #1;
        reset_n = 1'b0;
        #1;
        check("rstfill_clear", {busy, ram_we, done, error, i_dbg, state_dbg}, 16'd0);
        @(negedge clk); reset_n = 1'b1;
        w0 = wr_cnt;
        repeat (10) @(negedge clk);
        check("rstfill_quiet", {busy, 32'(wr_cnt - w0)}, 33'd0);

        check("done_busy_excl", overlap, 1'b0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
